// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-master arbiter in front of a single data memory port.
// The owner's bus signals are forwarded combinationally to the memory. The owner
// keeps the bus for at most MAX_XFER acknowledged transfers while the other
// master is waiting.
// Build option: define DMEM_ARB_RR_EN to break simultaneous requests round-robin
// against the last owner. When it is undefined, m0 has fixed priority.
module data_mem_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_XFER = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  output logic [DATA_W-1:0] m0_dat_o,
  output logic              m0_ack_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic              m1_ack_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [DATA_W-1:0] s_dat_o,
  input  logic [DATA_W-1:0] s_dat_i,
  input  logic              s_ack_i,
  output logic [1:0]        gnt_o
);

  localparam int unsigned CNT_W = $clog2(MAX_XFER + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_quota;
  logic             w_tie_m1;

  // The ack in this cycle is the one that uses up the owner's quota
  assign w_quota = s_ack_i && (r_cnt >= CNT_W'(MAX_XFER - 1));

`ifdef DMEM_ARB_RR_EN
  logic r_last;

  // Remember which master was granted most recently
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last <= 1'b0;
    end else if (w_next == OWN0 && r_state != OWN0) begin
      r_last <= 1'b0;
    end else if (w_next == OWN1 && r_state != OWN1) begin
      r_last <= 1'b1;
    end
  end

  assign w_tie_m1 = ~r_last;
`else
  assign w_tie_m1 = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: grant from IDLE, release on cyc drop, hand over once the quota is spent
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_next = w_tie_m1 ? OWN1 : OWN0;
        end else if (m0_cyc_i) begin
          w_next = OWN0;
        end else if (m1_cyc_i) begin
          w_next = OWN1;
        end
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          w_next = IDLE;
        end else if (m1_cyc_i && w_quota) begin
          w_next = OWN1;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          w_next = IDLE;
        end else if (m0_cyc_i && w_quota) begin
          w_next = OWN0;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Acked-transfer count for the current owner; cleared on any grant change, saturating
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if (r_state != IDLE && s_ack_i && r_cnt != CNT_W'(MAX_XFER)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Output decode: forward the owner's bus and route ack and read data back to it only
  always_comb begin
    gnt_o    = 2'b00;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_dat_o = '0;
    m1_dat_o = '0;
    case (r_state)
      OWN0: begin
        gnt_o    = 2'b01;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_dat_o = s_dat_i;
      end
      OWN1: begin
        gnt_o    = 2'b10;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_dat_o = s_dat_i;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: address width of all ports.
REQ-002 SHALL have parameter DATA_W, default 8: data width of all ports.
REQ-003 SHALL have parameter MAX_XFER, default 4: acked transfers an owner may complete while the other master waits.
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports mN_cyc_i / mN_stb_i / mN_we_i  input  1 each  bus cycle, strobe and write enable of master N, for N = 0, 1.
REQ-007 SHALL have port mN_adr_i  input  ADDR_W  master N address.
REQ-008 SHALL have port mN_dat_i  input  DATA_W  master N write data.
REQ-009 SHALL have port mN_dat_o  output  DATA_W  read data to master N.
REQ-010 SHALL have port mN_ack_o  output  1  acknowledge to master N.
REQ-011 SHALL have ports s_cyc_o / s_stb_o / s_we_o  output  1 each  cycle, strobe and write enable to the data memory.
REQ-012 SHALL have port s_adr_o  output  ADDR_W  memory address.
REQ-013 SHALL have port s_dat_o  output  DATA_W  memory write data.
REQ-014 SHALL have port s_dat_i  input  DATA_W  memory read data.
REQ-015 SHALL have port s_ack_i  input  1  memory acknowledge; write ack may be same-cycle, read ack one cycle after stb.
REQ-016 SHALL have port gnt_o  output  2  one-hot current owner (01 = m0, 10 = m1, 00 = none).

Function
REQ-017 SHALL implement FSM states IDLE, OWN0, OWN1; gnt_o decodes directly from the state.
REQ-018 IDLE: at the clock edge with mN_cyc_i high, SHALL move to OWNN; if both are high, SHALL choose per REQ-027/028.
REQ-019 Grant latency SHALL be exactly one cycle: slave signals are not driven in the cycle a request is first seen in IDLE.
REQ-020 In OWNN, s_cyc_o, s_stb_o, s_we_o, s_adr_o and s_dat_o SHALL equal master N inputs combinationally; in IDLE all s_* outputs SHALL be 0.
REQ-021 mN_ack_o SHALL be s_ack_i gated by ownership by N; the non-owner's ack SHALL be 0.
REQ-022 mN_dat_o SHALL be s_dat_i when N owns the bus, else 0.
REQ-023 Owner dropping mN_cyc_i SHALL return the FSM to IDLE at the next edge, regardless of the transfer count.
REQ-024 Transfer counter SHALL be ceil(log2(MAX_XFER+1)) bits, cleared on every grant, and incremented on each s_ack_i while owned; it SHALL saturate, never wrap.
REQ-025 When the counter reaches MAX_XFER and the other master's cyc is high, the FSM SHALL switch directly to the other owner at the next edge and clear the counter; the preempted master then stalls with ack = 0.
REQ-026 Preemption SHALL occur only on the edge following an ack, never with an unacked strobe outstanding.

Reset
REQ-029 rst_i high SHALL immediately force state IDLE, counter 0, last-owner 0, gnt_o = 00, all s_* outputs 0, both acks 0, both dat_o 0.
REQ-030 Reset mid-transfer SHALL abandon the transfer without any ack; after rst_i deassertion, arbitration SHALL restart from IDLE per REQ-018.

Configuration
REQ-031 Macro DMEM_ARB_RR_EN defined: round-robin; simultaneous requests SHALL be granted to the master other than the last owner, tracked in a 1-bit last-owner register.
REQ-027 With DMEM_ARB_RR_EN defined, the IDLE tie-break SHALL follow REQ-031.
REQ-028 Without DMEM_ARB_RR_EN: fixed priority; ties SHALL go to m0, no last-owner register SHALL exist, and REQ-025 still applies.

Verification
REQ-032 Single master: m0 writes 0xA5 to 0x10, then reads 0x10 -> gnt_o = 01 one cycle after cyc, m0_ack_o on write, read returns 0xA5 with ack 1 cycle after stb, m1_ack_o always 0.
REQ-033 Simultaneous cyc from both in IDLE, last-owner = m0, RR build -> gnt_o = 10; non-RR build -> gnt_o = 01.
REQ-034 m0 holds cyc for 6 writes with m1 requesting, MAX_XFER = 4 -> exactly 4 m0 acks, then gnt_o = 10 on the edge after the 4th ack; m0 resumes after m1 drops cyc.
REQ-035 m1 drops cyc after 2 reads, m0 idle -> FSM to IDLE next edge, gnt_o = 00, s_cyc_o = 0.
REQ-036 rst_i asserted while m1 read is pending -> gnt_o = 00 and s_stb_o = 0 immediately, no m1_ack_o; after release, m1 is re-granted in one cycle.
